// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Owns the GPR file and the read-only constant table, resolves decode-stage
//   source/destination indices into operand values (forwarding from execute,
//   then writeback), and registers them into the execute-stage operand
//   register with stall/flush control. One cycle of latency.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   dec_valid, dec_rc          decode valid; source-from-constant select
//   dec_src_idx, dec_dst_idx   decode source / destination indices
//   stall, flush               hold / invalidate the execute operand register
//   ex_fwd_en/idx/data         execute-stage forwarding path
//   wb_en/idx/data             single register-file write port
//   op_valid, src_val, dst_val execute operands
//   src_idx_q, dst_idx_q, rc_q registered decode fields
module operand_fetch_stage #(
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned NUM_REGS = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic              dec_rc,
  input  logic [IDX_W-1:0]  dec_src_idx,
  input  logic [IDX_W-1:0]  dec_dst_idx,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_fwd_en,
  input  logic [IDX_W-1:0]  ex_fwd_idx,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  output logic [DATA_W-1:0] src_val,
  output logic [DATA_W-1:0] dst_val,
  output logic [IDX_W-1:0]  src_idx_q,
  output logic [IDX_W-1:0]  dst_idx_q,
  output logic              rc_q
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] src_res;
  logic [DATA_W-1:0] dst_res;
  logic [DATA_W-1:0] src_reg_res;

  // Constant table: 0, powers of two 1..32, all-ones at 7, zero beyond.
  function automatic logic [DATA_W-1:0] const_val(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    case (32'(idx))
      1:       v = DATA_W'(1);
      2:       v = DATA_W'(2);
      3:       v = DATA_W'(4);
      4:       v = DATA_W'(8);
      5:       v = DATA_W'(16);
      6:       v = DATA_W'(32);
      7:       v = '1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Register operand resolution: execute forward beats writeback write-through.
  always_comb begin
    src_reg_res = regs[dec_src_idx];
    if (ex_fwd_en && (ex_fwd_idx == dec_src_idx))
      src_reg_res = ex_fwd_data;
    else if (wb_en && (wb_idx == dec_src_idx))
      src_reg_res = wb_data;

    dst_res = regs[dec_dst_idx];
    if (ex_fwd_en && (ex_fwd_idx == dec_dst_idx))
      dst_res = ex_fwd_data;
    else if (wb_en && (wb_idx == dec_dst_idx))
      dst_res = wb_data;

    // Constants bypass forwarding entirely.
    src_res = dec_rc ? const_val(dec_src_idx) : src_reg_res;
  end

  // Register file: single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_idx] <= wb_data;
    end
  end

  // Execute operand register: flush > stall (with writeback refresh) > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid  <= 1'b0;
      src_val   <= '0;
      dst_val   <= '0;
      src_idx_q <= '0;
      dst_idx_q <= '0;
      rc_q      <= 1'b0;
    end else if (flush) begin
      op_valid <= 1'b0;
    end else if (stall) begin
      // Keep held register operands coherent with writes landing mid-stall.
      if (op_valid && wb_en) begin
        if (!rc_q && (src_idx_q == wb_idx)) src_val <= wb_data;
        if (dst_idx_q == wb_idx)            dst_val <= wb_data;
      end
    end else begin
      op_valid  <= dec_valid;
      src_val   <= src_res;
      dst_val   <= dst_res;
      src_idx_q <= dec_src_idx;
      dst_idx_q <= dec_dst_idx;
      rc_q      <= dec_rc;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned IDX_W    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dec_valid, dec_rc;
  logic [IDX_W-1:0]  dec_src_idx, dec_dst_idx;
  logic              stall, flush;
  logic              ex_fwd_en;
  logic [IDX_W-1:0]  ex_fwd_idx;
  logic [DATA_W-1:0] ex_fwd_data;
  logic              wb_en;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              op_valid;
  logic [DATA_W-1:0] src_val, dst_val;
  logic [IDX_W-1:0]  src_idx_q, dst_idx_q;
  logic              rc_q;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [DATA_W-1:0] ctab [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
                                  16'h0008, 16'h0010, 16'h0020, 16'hFFFF};
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic              m_valid, m_rc;
  logic [DATA_W-1:0] m_src, m_dst;
  logic [IDX_W-1:0]  m_src_idx, m_dst_idx;

  always #5 clk = ~clk;

  operand_fetch_stage #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_rc(dec_rc),
    .dec_src_idx(dec_src_idx), .dec_dst_idx(dec_dst_idx),
    .stall(stall), .flush(flush),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .op_valid(op_valid), .src_val(src_val), .dst_val(dst_val),
    .src_idx_q(src_idx_q), .dst_idx_q(dst_idx_q), .rc_q(rc_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] resolve(input logic [IDX_W-1:0] r);
    if (ex_fwd_en && ex_fwd_idx == r) return ex_fwd_data;
    if (wb_en && wb_idx == r)         return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_REGS); i++) m_regs[i] = '0;
    m_valid = 0; m_rc = 0; m_src = '0; m_dst = '0; m_src_idx = '0; m_dst_idx = '0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".op_valid"}, 32'(op_valid), 32'(m_valid));
    if (m_valid) begin
      check({tag, ".src_val"},   32'(src_val),   32'(m_src));
      check({tag, ".dst_val"},   32'(dst_val),   32'(m_dst));
      check({tag, ".src_idx_q"}, 32'(src_idx_q), 32'(m_src_idx));
      check({tag, ".dst_idx_q"}, 32'(dst_idx_q), 32'(m_dst_idx));
      check({tag, ".rc_q"},      32'(rc_q),      32'(m_rc));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".op_valid"},  32'(op_valid),  0);
    check({tag, ".src_val"},   32'(src_val),   0);
    check({tag, ".dst_val"},   32'(dst_val),   0);
    check({tag, ".src_idx_q"}, 32'(src_idx_q), 0);
    check({tag, ".dst_idx_q"}, 32'(dst_idx_q), 0);
    check({tag, ".rc_q"},      32'(rc_q),      0);
  endtask

  task automatic drive(input logic v, input logic rc, input int s, input int d,
                       input logic st, input logic fl,
                       input logic xe, input int xi, input int xd,
                       input logic we, input int wi, input int wd);
    dec_valid = v; dec_rc = rc;
    dec_src_idx = IDX_W'(s); dec_dst_idx = IDX_W'(d);
    stall = st; flush = fl;
    ex_fwd_en = xe; ex_fwd_idx = IDX_W'(xi); ex_fwd_data = DATA_W'(xd);
    wb_en = we; wb_idx = IDX_W'(wi); wb_data = DATA_W'(wd);
  endtask

  // Advance the model by one edge, clock the DUT, then compare.
  task automatic cycle(input string tag);
    if (flush) begin
      m_valid = 0;
    end else if (stall) begin
      if (m_valid && wb_en) begin
        if (!m_rc && m_src_idx == wb_idx) m_src = wb_data;
        if (m_dst_idx == wb_idx)          m_dst = wb_data;
      end
    end else begin
      m_valid   = dec_valid;
      m_src     = dec_rc ? ctab[dec_src_idx] : resolve(dec_src_idx);
      m_dst     = resolve(dec_dst_idx);
      m_src_idx = dec_src_idx;
      m_dst_idx = dec_dst_idx;
      m_rc      = dec_rc;
    end
    if (wb_en) m_regs[wb_idx] = wb_data;
    @(posedge clk); #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0,0,0,0, 0,0, 0,0,0, 0,0,0);
    model_reset();
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write-then-read of reg3
    drive(0,0,0,0, 0,0, 0,0,0, 1,3,16'h1234); cycle("t1_wb");
    drive(1,0,3,3, 0,0, 0,0,0, 0,0,0);        cycle("t1_rd");
    check("t1_src_const", 32'(src_val), 32'h1234);
    check("t1_dst_const", 32'(dst_val), 32'h1234);

    // 2: constant source ignores forwarding
    drive(0,0,0,0, 0,0, 0,0,0, 1,2,16'h00AA); cycle("t2_wb");
    drive(1,1,5,2, 0,0, 1,5,16'hFFFF, 0,0,0); cycle("t2_c5");
    check("t2_src_c5", 32'(src_val), 32'h0010);
    check("t2_dst",    32'(dst_val), 32'h00AA);
    drive(1,1,7,2, 0,0, 1,5,16'hFFFF, 0,0,0); cycle("t2_c7");
    check("t2_src_c7", 32'(src_val), 32'hFFFF);

    // 3: execute forward beats writeback; writeback still lands
    drive(0,0,0,0, 0,0, 0,0,0, 1,1,16'h0001);        cycle("t3_wb");
    drive(1,0,1,0, 0,0, 1,1,16'h0BEE, 1,1,16'h0CAF); cycle("t3_fwd");
    check("t3_src_fwd", 32'(src_val), 32'h0BEE);
    drive(1,0,1,0, 0,0, 0,0,0, 0,0,0);               cycle("t3_reg");
    check("t3_src_reg", 32'(src_val), 32'h0CAF);

    // 4: writeback refresh of a held operand during a stall
    drive(0,0,0,0, 0,0, 0,0,0, 1,4,16'h0005); cycle("t4_wb");
    drive(1,0,0,4, 0,0, 0,0,0, 0,0,0);        cycle("t4_cap");
    check("t4_dst_cap", 32'(dst_val), 32'h0005);
    drive(1,0,0,4, 1,0, 0,0,0, 0,0,0);        cycle("t4_st1");
    check("t4_dst_st1", 32'(dst_val), 32'h0005);
    drive(1,0,0,4, 1,0, 0,0,0, 1,4,16'h0077); cycle("t4_st2");
    check("t4_dst_st2", 32'(dst_val), 32'h0077);
    drive(1,0,0,4, 1,0, 0,0,0, 0,0,0);        cycle("t4_st3");
    check("t4_dst_st3", 32'(dst_val), 32'h0077);
    drive(1,0,0,4, 0,0, 0,0,0, 0,0,0);        cycle("t4_rel");
    check("t4_dst_rel", 32'(dst_val), 32'h0077);

    // 5: flush beats stall
    drive(1,0,0,4, 1,1, 0,0,0, 0,0,0); cycle("t5_flush");
    check("t5_valid_lo", 32'(op_valid), 0);
    drive(1,0,0,4, 0,0, 0,0,0, 0,0,0); cycle("t5_reload");
    check("t5_valid_hi", 32'(op_valid), 1);

    // 6: asynchronous reset mid-cycle clears outputs and register file
    drive(1,0,6,6, 0,0, 0,0,0, 1,6,16'h1111); cycle("t6_wb");
    drive(1,0,6,6, 0,0, 0,0,0, 0,0,0);        cycle("t6_rd");
    check("t6_pre_src", 32'(src_val), 32'h1111);
    drive(1,0,6,6, 0,0, 0,0,0, 1,6,16'h2222);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    model_reset();
    #1 rst_n = 1'b1;
    drive(1,0,6,6, 0,0, 0,0,0, 0,0,0);        cycle("t6_after");
    check("t6_src_zero", 32'(src_val), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0,3) != 0), 1'($urandom), int'($urandom_range(0,7)),
            int'($urandom_range(0,7)),
            1'($urandom_range(0,3) == 0), 1'($urandom_range(0,9) == 0),
            1'($urandom), int'($urandom_range(0,7)), int'($urandom_range(0,65535)),
            1'($urandom), int'($urandom_range(0,7)), int'($urandom_range(0,65535)));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Successor to the combinational register/constant selector.
- Owns the general-purpose register file storage and the read-only constant table.
- Resolves decode-stage source/destination indices into operand values, forwarding from execute and writeback.
- Registers the result into the execute-stage operand register, with stall and flush control.
- Sits between decode and the ALU; the ALU consumes src_val/dst_val directly.

Parameters:
DATA_W, 16, operand/register width in bits
NUM_REGS, 8, number of GPRs and number of constant-table entries (power of 2, >= 8)
IDX_W, $clog2(NUM_REGS), index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode presents a valid instruction
dec_rc  in  1  1 = source operand comes from constant table, 0 = from register
dec_src_idx  in  IDX_W  source register/constant index
dec_dst_idx  in  IDX_W  destination register index (always a register)
stall  in  1  hold the execute operand register
flush  in  1  invalidate the execute operand register
ex_fwd_en  in  1  execute result is valid for forwarding this cycle
ex_fwd_idx  in  IDX_W  execute result destination
ex_fwd_data  in  DATA_W  execute result value
wb_en  in  1  writeback write enable
wb_idx  in  IDX_W  writeback destination
wb_data  in  DATA_W  writeback value
op_valid  out  1  execute operands valid
src_val  out  DATA_W  resolved source operand
dst_val  out  DATA_W  resolved destination operand
src_idx_q  out  IDX_W  registered source index
dst_idx_q  out  IDX_W  registered destination index
rc_q  out  1  registered dec_rc

Behaviour:
- Reset (rst_n low, asynchronous):
  - All GPRs, op_valid, src_val, dst_val, src_idx_q, dst_idx_q and rc_q are cleared to 0 immediately.
  - Reset asserted mid-operation discards any in-flight operand and any same-cycle write.
- Register file write:
  - On a rising edge with wb_en=1, reg[wb_idx] <= wb_data.
  - Exactly one write port; no other agent writes the file.
- Constant table (combinational, read-only):
  - Entry 0 = 0.
  - Entries 1..6 = 1, 2, 4, 8, 16, 32.
  - Entry 7 = all ones (-1).
  - Entries >= 8 = 0.
  - Values are zero-extended to DATA_W, except entry 7.
- Operand resolution for a register index r (combinational), in priority order:
  1. ex_fwd_en && ex_fwd_idx==r: ex_fwd_data
  2. else wb_en && wb_idx==r: wb_data (write-through)
  3. else reg[r]
- Source and destination selection:
  - src: if dec_rc=1, constant[dec_src_idx] with no forwarding; else the resolved register value.
  - dst: always the resolved register value of dec_dst_idx.
- Execute operand register, evaluated in this priority on each rising edge:
  - flush=1: op_valid <= 0. Value/index fields may update or hold; they are don't-care when op_valid=0. Flush beats stall.
  - else stall=1: all fields hold, with one exception (writeback refresh):
    - If op_valid=1 and wb_en=1, a held register operand whose index equals wb_idx is replaced by wb_data.
    - src is refreshed only when rc_q=0.
    - This prevents stale operands across multi-cycle stalls.
    - ex forwarding is not applied while stalled.
  - else: op_valid <= dec_valid. src_val, dst_val, src_idx_q, dst_idx_q and rc_q load the resolved decode values.
- Latency: 1 cycle from decode inputs to outputs.
- Decode must hold its inputs while stall=1; the block does not buffer more than one instruction.
- Arithmetic: none beyond selection. Indices are used modulo NUM_REGS; no out-of-range access is possible.

Test Plan:
1. Reset, then write reg3=0x1234 via wb. Next cycle decode src=3, dst=3, rc=0, valid=1 -> one cycle later op_valid=1, src_val=dst_val=0x1234.
2. rc=1, src_idx=5, dst_idx=2 with reg2=0x00AA, and ex_fwd to idx5=0xFFFF in the same cycle -> src_val=0x0010 (constant, not forwarded), dst_val=0x00AA. Repeat with src_idx=7 -> src_val=0xFFFF.
3. reg1=0x0001; in the same cycle ex_fwd idx1=0x0BEE and wb idx1=0x0CAF; decode src=1 -> src_val=0x0BEE. Following cycle with no ex_fwd -> register holds 0x0CAF.
4. Capture dst_idx=4 (reg4=0x0005), then assert stall for 3 cycles with wb idx4=0x0077 in the 2nd stall cycle -> dst_val=0x0005, then 0x0077, held through the stall release.
5. Assert stall and flush together with op_valid=1 -> op_valid=0 next edge. Release both with dec_valid=1 -> op_valid=1 next edge.
6. Assert rst_n low asynchronously between edges while op_valid=1 and reg6=0x1111 -> op_valid and all outputs 0 immediately. After release, a read of reg6 returns 0x0000.
